custom_logic_tld: RTL and testbench
===================================

CUSTOM_LOGIC_TLD -- requirements
Module: custom_logic_tld

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 1024, the maximum pixels per row held in each internal line buffer.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port n_rst  input  1  reset; one clock; reset is asynchronous and active-high (n_rst=1 resets).
REQ-004 SHALL have port startControlRegister  input  1  level start command.
REQ-005 SHALL have ports imageWidth / imageHeight  input  13 each  pixels per row / rows; legal range 2..MAX_WIDTH / >=2.
REQ-006 SHALL have ports start_addr_sdram / finish_addr_sdram  input  26 each  first read word / first write word.
REQ-007 SHALL have ports filterMode  input  2,  betaValue  input  8,  white  input  32 {unused, Rw, Gw, Bw}.
REQ-008 SHALL have ports data_sdram  input  32  read data, raw Bayer sample in [7:0];  sdram_datareadvalid  input  1  data qualifier.
REQ-009 SHALL have ports sdram_read_en  output  1,  sdram_write_en  output  1,  address_sdram  output  26,  writeData_sdram  output  32 {A,R,G,B},  finish_flag  output  1.

Function
REQ-010 SHALL implement FSM IDLE, START, READ, WAIT, STORE, NEXT, WPREP, WRITE, DONE; all outputs are registered or decoded from state only.
REQ-011 IDLE -> START when startControlRegister=1; START (1 cycle) loads read address=start_addr_sdram, write address=finish_addr_sdram, row=0, col=0, then -> READ.
REQ-012 READ: sdram_read_en=1 for exactly one cycle, address_sdram=read address; -> WAIT.
REQ-013 WAIT: sdram_read_en=0, address_sdram holds; remains until sdram_datareadvalid=1 at a rising edge, when data_sdram[7:0] is captured; -> STORE.
REQ-014 STORE: captured byte written into the current-row line buffer at col; -> NEXT.
REQ-015 NEXT: read address+1, col+1; if col < imageWidth-1 -> READ; else col=0 and: row 0 -> row=1, READ; row>=1 -> WPREP.
REQ-016 WPREP (1 cycle): computes output pixel x from 2x2 window prev[x], prev[x+1], cur[x], cur[x+1]; WRITE (1 cycle): sdram_write_en=1, address_sdram=write address, writeData_sdram=pixel; then write address+1, x+1.
REQ-017 Write pass emits imageWidth-1 pixels per row; after last: swap line buffers (cur becomes prev), row+1; row < imageHeight -> READ, else -> DONE.
REQ-018 Bayer RGGB by absolute position: (row,col) both even = R, both odd = B, otherwise G; window top-left is (row-1, x).
REQ-019 Raw pixel: R = R cell, B = B cell, G = (G1+G2)>>1 (9-bit sum, truncate); alpha = 8'hFF.
REQ-020 filterMode 00: raw pixel unchanged.
REQ-021 filterMode 01: each of R,G,B = min(255, ch + betaValue).
REQ-022 filterMode 10: each channel = (ch + previous raw pixel ch in same row)>>1; x=0 unchanged.
REQ-023 filterMode 11: each channel = (ch * (white_ch + 1))>>8, white_ch from white[23:16]/[15:8]/[7:0].
REQ-024 DONE: finish_flag=1, read/write enables 0; -> IDLE when startControlRegister=0.
REQ-025 Total reads = imageWidth*imageHeight; total writes = (imageWidth-1)*(imageHeight-1); read and write addresses never wrap within a frame (26-bit modular otherwise).
REQ-026 sdram_datareadvalid outside WAIT SHALL be ignored; startControlRegister changes outside IDLE/DONE ignored.

Reset
REQ-027 While n_rst=1: state=IDLE, all outputs 0, counters/addresses 0, immediately (asynchronous), including mid-frame; line buffer contents undefined.
REQ-028 After reset release, no activity until startControlRegister=1.

Verification
REQ-029 2x2, mode 00, start=0, finish=0, samples 10,20,30,40: reads at 0..3 (one read_en pulse each, 4 cycles/pixel with 1-cycle valid); one write at addr 0, data 0xFF0A1928; finish_flag=1.
REQ-030 Same image, mode 01, beta=50 -> 0xFF3C4B5A; with R sample 250 -> R=0xFF (saturate).
REQ-031 Same image, mode 11, white=0xFF808080 -> 0xFF050C14; white=0xFFFFFFFF -> 0xFF0A1928.
REQ-032 4x3, mode 10, finish=0x100: 6 writes at 0x100..0x105, 3 per row after each row's 4 reads; first of each row unblurred.
REQ-033 Delayed valid (5 cycles in WAIT): read_en stays 0, address held, no extra reads.
REQ-034 Assert n_rst mid-write-pass: outputs 0 same cycle; restart yields identical output stream.

Source files
------------

// File: rtl/custom_logic_tld.sv
// Bayer RGGB demosaic with a selectable colour filter.
// Reads a raw frame one sample at a time from SDRAM into two line buffers.
// After each row from the second onward, it writes one ARGB pixel for every
// 2x2 window that straddles the previous row and the current one.
module custom_logic_tld #(
  parameter int MAX_WIDTH = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        startControlRegister,
  input  logic [12:0] imageWidth,
  input  logic [12:0] imageHeight,
  input  logic [25:0] start_addr_sdram,
  input  logic [25:0] finish_addr_sdram,
  input  logic [1:0]  filterMode,
  input  logic [7:0]  betaValue,
  input  logic [31:0] white,
  input  logic [31:0] data_sdram,
  input  logic        sdram_datareadvalid,
  output logic        sdram_read_en,
  output logic        sdram_write_en,
  output logic [25:0] address_sdram,
  output logic [31:0] writeData_sdram,
  output logic        finish_flag
);

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [AW-1:0] ONE_IDX = 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_READ  = 4'd2;
  localparam logic [3:0] S_WAIT  = 4'd3;
  localparam logic [3:0] S_STORE = 4'd4;
  localparam logic [3:0] S_NEXT  = 4'd5;
  localparam logic [3:0] S_WPREP = 4'd6;
  localparam logic [3:0] S_WRITE = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]  state_q, state_d;
  logic [25:0] raddr_q, raddr_d;
  logic [25:0] waddr_q, waddr_d;
  logic [12:0] row_q, row_d;
  logic [12:0] col_q, col_d;
  logic        sel_q, sel_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] pix_q, pix_d;
  logic [23:0] prev_q, prev_d;

  // sel_q=0: buf0 holds the current row and buf1 the previous one.
  logic [7:0] buf0_mem [MAX_WIDTH];
  logic [7:0] buf1_mem [MAX_WIDTH];

  logic [AW-1:0] x_idx, x1_idx;
  logic [7:0]    p_tl, p_tr, p_bl, p_br;
  logic [8:0]    g_sum;
  logic [7:0]    raw_r, raw_g, raw_b;
  logic [7:0]    f_r, f_g, f_b;
  logic          unused_ok;

  assign unused_ok = ^{white[31:24], data_sdram[31:8], g_sum[0]};

  // One channel of the selected post-filter applied to a raw channel value.
  function automatic logic [7:0] filt(input logic [1:0] mode, input logic [7:0] ch,
                                      input logic [7:0] prev, input logic [7:0] beta,
                                      input logic [7:0] wc, input logic first);
    logic [8:0]  s;
    logic [15:0] p;
    s = '0;
    p = '0;
    filt = ch;
    case (mode)
      2'b01: begin
        s = {1'b0, ch} + {1'b0, beta};
        filt = s[8] ? 8'hFF : s[7:0];
      end
      2'b10: begin
        s = {1'b0, ch} + {1'b0, prev};
        filt = first ? ch : s[8:1];
      end
      2'b11: begin
        p = {8'b0, ch} * ({8'b0, wc} + 16'd1);
        filt = p[15:8];
      end
      default: filt = ch;
    endcase
  endfunction

  // Capture each stored sample into the current-row buffer.
  // NOTE: line buffers have no reset; their contents are always written before being read in a frame.
  always_ff @(posedge clk) begin
    if (state_q == S_STORE) begin
      if (sel_q) buf1_mem[col_q[AW-1:0]] <= byte_q;
      else       buf0_mem[col_q[AW-1:0]] <= byte_q;
    end
  end

  // Fetch the 2x2 window and demosaic it according to the Bayer phase of its top-left cell.
  always_comb begin
    x_idx  = col_q[AW-1:0];
    x1_idx = x_idx + ONE_IDX;
    p_tl   = sel_q ? buf0_mem[x_idx]  : buf1_mem[x_idx];
    p_tr   = sel_q ? buf0_mem[x1_idx] : buf1_mem[x1_idx];
    p_bl   = sel_q ? buf1_mem[x_idx]  : buf0_mem[x_idx];
    p_br   = sel_q ? buf1_mem[x1_idx] : buf0_mem[x1_idx];
    // Top row of the window is row_q-1, so its parity is the inverse of row_q[0].
    case ({~row_q[0], col_q[0]})
      2'b00:   begin raw_r = p_tl; raw_b = p_br; g_sum = {1'b0, p_tr} + {1'b0, p_bl}; end
      2'b01:   begin raw_r = p_tr; raw_b = p_bl; g_sum = {1'b0, p_tl} + {1'b0, p_br}; end
      2'b10:   begin raw_r = p_bl; raw_b = p_tr; g_sum = {1'b0, p_tl} + {1'b0, p_br}; end
      default: begin raw_r = p_br; raw_b = p_tl; g_sum = {1'b0, p_tr} + {1'b0, p_bl}; end
    endcase
    raw_g = g_sum[8:1];
    f_r = filt(filterMode, raw_r, prev_q[23:16], betaValue, white[23:16], col_q == 13'd0);
    f_g = filt(filterMode, raw_g, prev_q[15:8],  betaValue, white[15:8],  col_q == 13'd0);
    f_b = filt(filterMode, raw_b, prev_q[7:0],   betaValue, white[7:0],   col_q == 13'd0);
  end

  // Next-state and datapath updates for the read and write passes.
  // NOTE: every signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    row_d   = row_q;
    col_d   = col_q;
    sel_d   = sel_q;
    byte_d  = byte_q;
    pix_d   = pix_q;
    prev_d  = prev_q;
    case (state_q)
      S_IDLE:  if (startControlRegister) state_d = S_START;
      S_START: begin
        raddr_d = start_addr_sdram;
        waddr_d = finish_addr_sdram;
        row_d   = 13'd0;
        col_d   = 13'd0;
        state_d = S_READ;
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  if (sdram_datareadvalid) begin
        byte_d  = data_sdram[7:0];
        state_d = S_STORE;
      end
      S_STORE: state_d = S_NEXT;
      S_NEXT: begin
        raddr_d = raddr_q + 26'd1;
        if (col_q < imageWidth - 13'd1) begin
          col_d   = col_q + 13'd1;
          state_d = S_READ;
        end else begin
          col_d = 13'd0;
          if (row_q == 13'd0) begin
            row_d   = 13'd1;
            sel_d   = ~sel_q;
            state_d = S_READ;
          end else begin
            state_d = S_WPREP;
          end
        end
      end
      S_WPREP: begin
        pix_d   = {8'hFF, f_r, f_g, f_b};
        prev_d  = {raw_r, raw_g, raw_b};
        state_d = S_WRITE;
      end
      S_WRITE: begin
        waddr_d = waddr_q + 26'd1;
        if (col_q < imageWidth - 13'd2) begin
          col_d   = col_q + 13'd1;
          state_d = S_WPREP;
        end else begin
          col_d   = 13'd0;
          sel_d   = ~sel_q;
          row_d   = row_q + 13'd1;
          state_d = (row_q + 13'd1 < imageHeight) ? S_READ : S_DONE;
        end
      end
      S_DONE:  if (!startControlRegister) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by n_rst (active high).
  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      waddr_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sel_q   <= 1'b0;
      byte_q  <= '0;
      pix_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sel_q   <= sel_d;
      byte_q  <= byte_d;
      pix_q   <= pix_d;
      prev_q  <= prev_d;
    end
  end

  assign sdram_read_en   = (state_q == S_READ);
  assign sdram_write_en  = (state_q == S_WRITE);
  assign finish_flag     = (state_q == S_DONE);
  assign address_sdram   = (state_q == S_WRITE) ? waddr_q : raddr_q;
  assign writeData_sdram = pix_q;

endmodule

// File: tb/tb_custom_logic_tld.sv
// Self-checking bench for custom_logic_tld: an SDRAM responder, an output
// monitor, and a per-cell Bayer reference model that predicts every write.
module tb_custom_logic_tld;

  localparam int MW = 16;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [12:0] img_w, img_h;
  logic [25:0] sa, fa;
  logic [1:0]  mode;
  logic [7:0]  beta;
  logic [31:0] wht;
  logic [31:0] data_sdram;
  logic        valid;
  logic        read_en, write_en;
  logic [25:0] addr;
  logic [31:0] wdata;
  logic        finish_flag;

  custom_logic_tld #(.MAX_WIDTH(MW)) dut (
    .clk(clk), .n_rst(n_rst), .startControlRegister(start),
    .imageWidth(img_w), .imageHeight(img_h),
    .start_addr_sdram(sa), .finish_addr_sdram(fa),
    .filterMode(mode), .betaValue(beta), .white(wht),
    .data_sdram(data_sdram), .sdram_datareadvalid(valid),
    .sdram_read_en(read_en), .sdram_write_en(write_en),
    .address_sdram(addr), .writeData_sdram(wdata), .finish_flag(finish_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  img [256];
  logic [25:0] rd_q[$];
  logic [25:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          rd_cyc[$];
  int          wr_cyc[$];
  logic [25:0] e_addr[$];
  logic [31:0] e_data[$];
  int          cyc = 0;
  int          dmin = 1;
  int          dmax = 1;
  bit          chk_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: log every read pulse and write pulse with its cycle number.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (read_en) begin rd_q.push_back(addr); rd_cyc.push_back(cyc); end
    if (write_en) begin wa_q.push_back(addr); wd_q.push_back(wdata); wr_cyc.push_back(cyc); end
  end

  // SDRAM responder: answer each read after a random latency with a one-cycle valid.
  initial begin
    logic [25:0] a, off;
    logic [31:0] junk;
    int d, idx;
    valid = 1'b0;
    data_sdram = '0;
    forever begin
      @(negedge clk);
      if (read_en) begin
        a = addr;
        d = $urandom_range(dmax, dmin);
        repeat (d) begin
          @(negedge clk);
          if (chk_hold) begin
            check("hold_read_en", 64'(read_en), 64'd0);
            check("hold_addr", 64'(addr), 64'(a));
          end
        end
        off = a - sa;
        idx = (off < 26'd256) ? int'(off) : 0;
        junk = $urandom;
        data_sdram = {junk[23:0], img[idx]};
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        junk = $urandom;
        data_sdram = junk;
      end
    end
  end

  function automatic int color(input int r, input int c);
    if ((r % 2 == 0) && (c % 2 == 0)) return 0;
    if ((r % 2 == 1) && (c % 2 == 1)) return 2;
    return 1;
  endfunction

  function automatic int apply(input int ch, input int prv, input int wc, input bit first);
    case (mode)
      2'd1:    return (ch + int'(beta) > 255) ? 255 : ch + int'(beta);
      2'd2:    return first ? ch : (ch + prv) / 2;
      2'd3:    return (ch * (wc + 1)) / 256;
      default: return ch;
    endcase
  endfunction

  // Reference model: classify each window cell by absolute Bayer position.
  task automatic build_expected(input int w, input int h);
    int rgb[3], prv[3], gs, k, rr, cc, col, fr, fg, fb;
    e_addr.delete();
    e_data.delete();
    k = 0;
    for (int r = 1; r < h; r++) begin
      for (int x = 0; x < w - 1; x++) begin
        rgb[0] = 0; rgb[2] = 0; gs = 0;
        for (int c = 0; c < 4; c++) begin
          rr = r - 1 + c / 2;
          cc = x + c % 2;
          col = color(rr, cc);
          if (col == 1) gs += int'(img[rr * w + cc]);
          else rgb[col] = int'(img[rr * w + cc]);
        end
        rgb[1] = gs / 2;
        fr = apply(rgb[0], prv[0], int'(wht[23:16]), x == 0);
        fg = apply(rgb[1], prv[1], int'(wht[15:8]),  x == 0);
        fb = apply(rgb[2], prv[2], int'(wht[7:0]),   x == 0);
        prv = rgb;
        e_addr.push_back(fa + 26'(k));
        e_data.push_back({8'hFF, 8'(fr), 8'(fg), 8'(fb)});
        k++;
      end
    end
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] m, input logic [7:0] b,
                           input logic [31:0] wv, input logic [25:0] s, input logic [25:0] f,
                           input int d0, input int d1);
    int t, budget, n;
    @(negedge clk);
    img_w = 13'(w); img_h = 13'(h); mode = m; beta = b; wht = wv; sa = s; fa = f;
    dmin = d0; dmax = d1;
    rd_q.delete(); wa_q.delete(); wd_q.delete(); rd_cyc.delete(); wr_cyc.delete();
    start = 1'b1;
    budget = w * h * (d1 + 8) + 100;
    t = 0;
    while (!finish_flag && t < budget) begin @(negedge clk); t++; end
    check("finish_flag", 64'(finish_flag), 64'd1);
    check("done_read_en", 64'(read_en), 64'd0);
    check("done_write_en", 64'(write_en), 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_finish", 64'(finish_flag), 64'd0);
    check("read_count", 64'(rd_q.size()), 64'(w * h));
    n = (rd_q.size() < w * h) ? rd_q.size() : w * h;
    for (int i = 0; i < n; i++) check("read_addr", 64'(rd_q[i]), 64'(s + 26'(i)));
    build_expected(w, h);
    check("write_count", 64'(wa_q.size()), 64'(e_addr.size()));
    n = (wa_q.size() < e_addr.size()) ? wa_q.size() : e_addr.size();
    for (int i = 0; i < n; i++) begin
      check("write_addr", 64'(wa_q[i]), 64'(e_addr[i]));
      check("write_data", 64'(wd_q[i]), 64'(e_data[i]));
    end
  endtask

  initial begin
    int w, h, t;
    logic [31:0] r32;
    start = 1'b0; img_w = 13'd2; img_h = 13'd2; sa = '0; fa = '0;
    mode = '0; beta = '0; wht = '0;
    n_rst = 1'b0;
    #2 n_rst = 1'b1;
    #1;
    check("rst_read_en", 64'(read_en), 64'd0);
    check("rst_write_en", 64'(write_en), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_finish", 64'(finish_flag), 64'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_no_reads", 64'(rd_q.size()), 64'd0);
    check("idle_no_writes", 64'(wa_q.size()), 64'd0);

    // 2x2 raw pass-through with minimum latency.
    img[0] = 8'd10; img[1] = 8'd20; img[2] = 8'd30; img[3] = 8'd40;
    run_frame(2, 2, 2'd0, 8'd0, 32'd0, 26'd0, 26'd0, 1, 1);
    if (wd_q.size() > 0) check("raw_2x2_data", 64'(wd_q[0]), 64'h00000000FF0A1928);
    for (int i = 0; i + 1 < rd_cyc.size(); i++)
      check("read_spacing", 64'(rd_cyc[i + 1] - rd_cyc[i]), 64'd4);

    run_frame(2, 2, 2'd1, 8'd50, 32'd0, 26'd0, 26'd0, 1, 2);
    if (wd_q.size() > 0) check("beta_data", 64'(wd_q[0]), 64'h00000000FF3C4B5A);
    img[0] = 8'd250;
    run_frame(2, 2, 2'd1, 8'd50, 32'd0, 26'd0, 26'd0, 1, 2);
    if (wd_q.size() > 0) check("beta_sat_data", 64'(wd_q[0]), 64'h00000000FFFF4B5A);
    img[0] = 8'd10;
    run_frame(2, 2, 2'd3, 8'd0, 32'hFF808080, 26'd0, 26'd0, 1, 2);
    if (wd_q.size() > 0) check("wb_half_data", 64'(wd_q[0]), 64'h00000000FF050C14);
    run_frame(2, 2, 2'd3, 8'd0, 32'hFFFFFFFF, 26'd0, 26'd0, 1, 2);
    if (wd_q.size() > 0) check("wb_unity_data", 64'(wd_q[0]), 64'h00000000FF0A1928);

    // 4x3 blur: three writes land between each row's last read and the next row's first read.
    for (int i = 0; i < 12; i++) begin r32 = $urandom; img[i] = r32[7:0]; end
    run_frame(4, 3, 2'd2, 8'd0, 32'd0, 26'd40, 26'h100, 1, 3);
    for (int k = 0; k < wr_cyc.size() && rd_cyc.size() == 12; k++) begin
      check("blur_after_row", 64'(wr_cyc[k] > rd_cyc[(k / 3 + 2) * 4 - 1]), 64'd1);
      if (k < 3) check("blur_before_next", 64'(wr_cyc[k] < rd_cyc[8]), 64'd1);
    end

    // Five-cycle valid latency: address and read enable hold steady while waiting.
    chk_hold = 1'b1;
    run_frame(2, 2, 2'd0, 8'd0, 32'd0, 26'd7, 26'd9, 5, 5);
    chk_hold = 1'b0;

    // Randomized frames in every filter mode.
    for (int f = 0; f < 8; f++) begin
      w = $urandom_range(MW, 2);
      h = $urandom_range(5, 2);
      for (int i = 0; i < w * h; i++) begin r32 = $urandom; img[i] = r32[7:0]; end
      r32 = $urandom;
      run_frame(w, h, 2'(f % 4), r32[7:0], $urandom, 26'($urandom_range(50000, 0)),
                26'($urandom_range(50000, 0)), 1, 3);
    end

    // Reset in the middle of the write pass, then restart the same frame.
    w = 5; h = 4;
    for (int i = 0; i < w * h; i++) begin r32 = $urandom; img[i] = r32[7:0]; end
    @(negedge clk);
    img_w = 13'(w); img_h = 13'(h); mode = 2'd2; sa = 26'd300; fa = 26'd900;
    wa_q.delete(); wd_q.delete();
    start = 1'b1;
    t = 0;
    while (wa_q.size() < 2 && t < 2000) begin @(negedge clk); t++; end
    check("pre_reset_writes", 64'(wa_q.size() >= 2), 64'd1);
    @(posedge clk);
    #2 n_rst = 1'b1;
    #1;
    check("midrst_read_en", 64'(read_en), 64'd0);
    check("midrst_write_en", 64'(write_en), 64'd0);
    check("midrst_addr", 64'(addr), 64'd0);
    check("midrst_wdata", 64'(wdata), 64'd0);
    check("midrst_finish", 64'(finish_flag), 64'd0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    rd_q.delete();
    repeat (8) @(negedge clk);
    check("post_rst_quiet", 64'(rd_q.size()), 64'd0);
    run_frame(w, h, 2'd2, 8'd0, 32'd0, 26'd300, 26'd900, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
